// File: rtl/dds_sine_gen_pkg.sv
// Shared constants for the DDS sine source.
//   ACC_W  : phase accumulator width
//   ADDR_W : sine lookup address width (accumulator MSBs)
//   DATA_W : signed sample width
//   QTAB   : quarter-wave table, QTAB[k] = round(63*sin(2*pi*k/256)), k = 0..64
package dds_sine_gen_pkg;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 7;

  localparam logic [DATA_W-1:0] QTAB [0:64] = '{
    7'd0,  7'd2,  7'd3,  7'd5,  7'd6,  7'd8,  7'd9,  7'd11,
    7'd12, 7'd14, 7'd15, 7'd17, 7'd18, 7'd20, 7'd21, 7'd23,
    7'd24, 7'd26, 7'd27, 7'd28, 7'd30, 7'd31, 7'd32, 7'd34,
    7'd35, 7'd36, 7'd38, 7'd39, 7'd40, 7'd41, 7'd42, 7'd43,
    7'd45, 7'd46, 7'd47, 7'd48, 7'd49, 7'd50, 7'd51, 7'd52,
    7'd52, 7'd53, 7'd54, 7'd55, 7'd56, 7'd56, 7'd57, 7'd58,
    7'd58, 7'd59, 7'd59, 7'd60, 7'd60, 7'd61, 7'd61, 7'd61,
    7'd62, 7'd62, 7'd62, 7'd63, 7'd63, 7'd63, 7'd63, 7'd63,
    7'd63
  };

endpackage

// File: rtl/dds_sine_rom.sv
// Registered sine lookup built from a quarter-wave table with quadrant folding.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears the sample
//   addr : 8-bit phase address
//   dout : 7-bit two's-complement sample S(addr), one cycle after addr
module dds_sine_rom
  import dds_sine_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);

  logic signed [DATA_W-1:0] dout_p1_d;
  logic signed [DATA_W-1:0] dout_p1_q;

  // addr[6] mirrors the quarter (reads T[64-q]); addr[7] negates the half.
  // The table peak is +63, so negation never needs saturation.
  function automatic logic signed [DATA_W-1:0] fold_quadrant(input logic [ADDR_W-1:0] a);
    logic [6:0]               idx;
    logic signed [DATA_W-1:0] mag;
    idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = signed'(QTAB[idx]);
    return a[7] ? -mag : mag;
  endfunction

  always_comb begin
    dout_p1_d = fold_quadrant(addr);
  end

  // p0 -> p1: address to registered sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_p1_q <= '0;
    end else begin
      dout_p1_q <= dout_p1_d;
    end
  end

  assign dout = dout_p1_q;

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine source: a 32-bit phase accumulator advanced by freqctrl every
// clock; its top 8 bits address a registered 256-point signed sine lookup.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   freqctrl : frequency tuning word F, fout = F*fclk/2^32
//   addr     : current phase address, accumulator[31:24]
//   dout     : signed 7-bit sine sample, one cycle behind addr
module dds_sine_gen
  import dds_sine_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ACC_W-1:0]  freqctrl,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);

  logic [ACC_W-1:0] acc_p0_d;
  logic [ACC_W-1:0] acc_p0_q;

  // Modulo-2^32 wrap is the natural overflow; retuning never clears the
  // accumulator, so frequency changes are phase-continuous.
  always_comb begin
    acc_p0_d = acc_p0_q + freqctrl;
  end

  // p0: phase accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0_q <= '0;
    end else begin
      acc_p0_q <= acc_p0_d;
    end
  end

  assign addr = acc_p0_q[ACC_W-1 -: ADDR_W];

  // p0 -> p1: sine lookup
  dds_sine_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .dout (dout)
  );

endmodule

// File: tb/tb_dds_sine_gen.sv
module tb_dds_sine_gen;

  logic        clk;
  logic        rst;
  logic [31:0] freqctrl;
  logic [7:0]  addr;
  logic [6:0]  dout;

  int          checks;
  int          errors;
  bit   [31:0] acc_m;
  bit   [31:0] f_m;
  int          last_pa;
  int          seen [0:255];

  localparam real PI = 3.14159265358979323846;

  dds_sine_gen dut (
    .clk      (clk),
    .rst      (rst),
    .freqctrl (freqctrl),
    .addr     (addr),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct evaluation of round(63*sin(2*pi*a/256)), rounding half away from zero.
  function automatic int s_model(input int a);
    real x;
    x = 63.0 * $sin(2.0 * PI * a / 256.0);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_f(input bit [31:0] v);
    freqctrl = v;
    f_m      = v;
  endtask

  // Called #1 after an edge: assert reset, hold across one edge, release.
  task automatic do_reset(input bit [31:0] v);
    rst = 1'b1;
    set_f(v);
    @(posedge clk); #1;
    rst   = 1'b0;
    acc_m = '0;
  endtask

  // One clock edge, then check addr against the model accumulator and dout
  // against S of the address that was current before the edge.
  task automatic step(input string tag);
    int pa;
    pa = int'(acc_m[31:24]);
    @(posedge clk); #1;
    acc_m = acc_m + f_m;
    chk({tag, "_addr"}, int'(addr), int'(acc_m[31:24]));
    chk({tag, "_dout"}, int'($signed(dout)), s_model(pa));
    last_pa = pa;
  endtask

  initial begin
    int n_wrap;
    int last_wrap;
    int pk_pos;
    int pk_neg;
    int prev_addr;
    int prev_dout;
    int cur;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_f(32'd0);
    acc_m  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", int'(addr), 0);
    chk("rst_dout", int'($signed(dout)), 0);

    // Table sweep, one address per cycle
    do_reset(32'h0100_0000);
    for (int n = 1; n <= 256; n++) begin
      step("sweep");
      seen[last_pa] = int'($signed(dout));
      case (last_pa)
        0:   chk("pt_s0",   int'($signed(dout)), 0);
        16:  chk("pt_s16",  int'($signed(dout)), 24);
        32:  chk("pt_s32",  int'($signed(dout)), 45);
        64:  chk("pt_s64",  int'($signed(dout)), 63);
        128: chk("pt_s128", int'($signed(dout)), 0);
        192: chk("pt_s192", int'($signed(dout)), -63);
        default: ;
      endcase
    end
    for (int a = 0; a < 128; a++) begin
      chk("odd_sym", seen[a + 128], -seen[a]);
    end

    // Asynchronous reset mid-cycle: clears before the next edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst_addr", int'(addr), 0);
    chk("arst_dout", int'($signed(dout)), 0);
    @(posedge clk); #1;
    rst   = 1'b0;
    acc_m = '0;
    step("rel1");
    chk("rel1_addr_hc", int'(addr), 1);
    step("rel2");
    chk("rel2_addr_hc", int'(addr), 2);
    step("rel3");
    chk("rel3_addr_hc", int'(addr), 3);

    // Hold at addr 64 with F=0
    do_reset(32'h0100_0000);
    repeat (64) step("to64");
    set_f(32'd0);
    for (int i = 0; i < 10; i++) begin
      step("hold");
      chk("hold_addr_hc", int'(addr), 64);
      chk("hold_dout_hc", int'($signed(dout)), 63);
    end

    // Wrap with F = 2^32-1: addr 255 from the first edge
    do_reset(32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      step("wrapm1");
      chk("wrapm1_addr_hc", int'(addr), 255);
    end

    // F = 2^31: addr alternates 128/0, dout constantly 0
    do_reset(32'h8000_0000);
    for (int i = 1; i <= 6; i++) begin
      step("half");
      chk("half_addr_hc", int'(addr), (i % 2 == 1) ? 128 : 0);
      chk("half_dout_hc", int'($signed(dout)), 0);
    end

    // Retune from 2^24 to 2^25 at addr 10, no phase reset
    do_reset(32'h0100_0000);
    repeat (10) step("pre");
    chk("retune_at10", int'(addr), 10);
    set_f(32'h0200_0000);
    step("rt1");
    chk("rt1_addr_hc", int'(addr), 12);
    step("rt2");
    chk("rt2_addr_hc", int'(addr), 14);
    step("rt3");
    chk("rt3_addr_hc", int'(addr), 16);

    // Reference tuning word: ~5000-cycle period
    do_reset(32'd858993);
    n_wrap    = 0;
    last_wrap = 0;
    pk_pos    = 0;
    pk_neg    = 0;
    prev_addr = int'(addr);
    prev_dout = int'($signed(dout));
    for (int c = 1; c <= 20000; c++) begin
      @(posedge clk); #1;
      if (int'(addr) < prev_addr) begin
        if (n_wrap > 0) begin
          chk("period", ((c - last_wrap) >= 4999 && (c - last_wrap) <= 5001) ? 1 : 0, 1);
        end
        n_wrap++;
        last_wrap = c;
      end
      cur = int'($signed(dout));
      if (cur == 63 && prev_dout != 63)   pk_pos++;
      if (cur == -63 && prev_dout != -63) pk_neg++;
      prev_addr = int'(addr);
      prev_dout = cur;
    end
    chk("wrap_count", n_wrap, 3);
    chk("peak_pos_count", pk_pos, 4);
    chk("peak_neg_count", pk_neg, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
